// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Selects the retiring result (ALU or
// load data), commits it to the 16-entry architectural register file, keeps
// the per-register busy scoreboard and counts retired instructions.
// All state updates happen on the falling edge of I_CLOCK.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> read ports forward the same-cycle commit value
//   undefined -> read ports return stored register contents only
//
// Opcode encoding (OPCODE_WIDTH = 8):
//   ADD_D 10 ADDI_D 11 AND_D 12 ANDI_D 13 MOV 14 MOVI_D 15 LDW 16 STW 17
//   BRN..BRNZP 18..1E  JMP 1F  JSR 20  JSRR 21  (anything else: unknown)

module writeback_stage #(
    parameter int NUM_REGS     = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int REG_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic [REG_WIDTH-1:0]    I_ALUOut,
    input  logic [REG_WIDTH-1:0]    I_MemOut,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]              I_DestRegIdx,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    input  logic [3:0]              I_RdIdx0,
    input  logic [3:0]              I_RdIdx1,
    output logic [REG_WIDTH-1:0]    O_RdData0,
    output logic [REG_WIDTH-1:0]    O_RdData1,
    input  logic                    I_SetBusy,
    input  logic [3:0]              I_SetBusyIdx,
    output logic [NUM_REGS-1:0]     O_BusyVec,
    output logic                    O_WBValid,
    output logic [3:0]              O_WBIdx,
    output logic [REG_WIDTH-1:0]    O_WBValue,
    output logic [CNT_WIDTH-1:0]    O_RetireCount
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = 8'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = 8'h13;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = 8'h14;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = 8'h15;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = 8'h16;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = 8'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = 8'h21;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0]  BIT_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // True for opcodes that write a destination register.
    function automatic logic is_writer(input logic [OPCODE_WIDTH-1:0] op);
        logic w;
        case (op)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D,
            OP_MOV, OP_MOVI_D, OP_LDW, OP_JSR, OP_JSRR: w = 1'b1;
            default:                                    w = 1'b0;
        endcase
        return w;
    endfunction

    logic [REG_WIDTH-1:0] rf_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 wb_valid_q;
    logic [3:0]           wb_idx_q;
    logic [REG_WIDTH-1:0] wb_value_q;

    logic                 retire_s;
    logic                 commit_s;
    logic [REG_WIDTH-1:0] value_s;
    logic [NUM_REGS-1:0]  clr_mask_s;
    logic [NUM_REGS-1:0]  set_mask_s;

    // Retire/commit decode and result selection (load data only for LDW).
    always_comb begin
        retire_s = I_LOCK & ~I_FetchStall & ~I_DepStall;
        commit_s = retire_s & is_writer(I_Opcode);
        if (I_Opcode == OP_LDW) begin
            value_s = I_MemOut;
        end else begin
            value_s = I_ALUOut;
        end
    end

    // Scoreboard next state: clear on commit, then set from decode so that a
    // same-index set wins (the newer producer is still outstanding).
    always_comb begin
        if (commit_s) begin
            clr_mask_s = BIT_ONE << I_DestRegIdx;
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
        if (I_SetBusy) begin
            set_mask_s = BIT_ONE << I_SetBusyIdx;
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Saturating retired-instruction counter.
    always_comb begin
        if (retire_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Architectural state update on the falling edge; reset dominates.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= {REG_WIDTH{1'b0}};
            end
            busy_q     <= {NUM_REGS{1'b0}};
            cnt_q      <= {CNT_WIDTH{1'b0}};
            wb_valid_q <= 1'b0;
            wb_idx_q   <= 4'd0;
            wb_value_q <= {REG_WIDTH{1'b0}};
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= commit_s;
            if (commit_s) begin
                rf_q[I_DestRegIdx] <= value_s;
                wb_idx_q           <= I_DestRegIdx;
                wb_value_q         <= value_s;
            end else begin
                wb_idx_q   <= wb_idx_q;
                wb_value_q <= wb_value_q;
            end
        end
    end

    // Combinational read ports, optionally forwarding the in-flight commit.
    always_comb begin
`ifdef WB_BYPASS_EN
        if (commit_s && (I_RdIdx0 == I_DestRegIdx)) begin
            O_RdData0 = value_s;
        end else begin
            O_RdData0 = rf_q[I_RdIdx0];
        end
        if (commit_s && (I_RdIdx1 == I_DestRegIdx)) begin
            O_RdData1 = value_s;
        end else begin
            O_RdData1 = rf_q[I_RdIdx1];
        end
`else
        O_RdData0 = rf_q[I_RdIdx0];
        O_RdData1 = rf_q[I_RdIdx1];
`endif
    end

    assign O_BusyVec     = busy_q;
    assign O_RetireCount = cnt_q;
    assign O_WBValid     = wb_valid_q;
    assign O_WBIdx       = wb_idx_q;
    assign O_WBValue     = wb_value_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a driver applies directed and random
// cycles, a reference model predicts each cycle's registered outputs into a
// queue, and a monitor pops and compares them after the next falling edge.
// The counter is built 8 bits wide so saturation is reachable.

module tb_writeback_stage;

    localparam int CW = 8;

    localparam logic [7:0] ADD_D  = 8'h10;
    localparam logic [7:0] ADDI_D = 8'h11;
    localparam logic [7:0] AND_D  = 8'h12;
    localparam logic [7:0] ANDI_D = 8'h13;
    localparam logic [7:0] MOV    = 8'h14;
    localparam logic [7:0] MOVI_D = 8'h15;
    localparam logic [7:0] LDW    = 8'h16;
    localparam logic [7:0] STW    = 8'h17;
    localparam logic [7:0] BRZ    = 8'h19;
    localparam logic [7:0] JMP    = 8'h1F;
    localparam logic [7:0] JSR    = 8'h20;
    localparam logic [7:0] JSRR   = 8'h21;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lock = 1'b0;
    logic [15:0] alu = 16'h0;
    logic [15:0] mem = 16'h0;
    logic [7:0]  op = 8'h0;
    logic [3:0]  dst = 4'h0;
    logic        fs = 1'b0;
    logic        ds = 1'b0;
    logic [3:0]  r0 = 4'h0;
    logic [3:0]  r1 = 4'h0;
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic        sb = 1'b0;
    logic [3:0]  sbi = 4'h0;
    logic [15:0] busy;
    logic        wbv;
    logic [3:0]  wbi;
    logic [15:0] wbval;
    logic [CW-1:0] cnt;

    writeback_stage #(.CNT_WIDTH(CW)) dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock),
        .I_ALUOut(alu), .I_MemOut(mem), .I_Opcode(op), .I_DestRegIdx(dst),
        .I_FetchStall(fs), .I_DepStall(ds),
        .I_RdIdx0(r0), .I_RdIdx1(r1), .O_RdData0(rd0), .O_RdData1(rd1),
        .I_SetBusy(sb), .I_SetBusyIdx(sbi), .O_BusyVec(busy),
        .O_WBValid(wbv), .O_WBIdx(wbi), .O_WBValue(wbval),
        .O_RetireCount(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, lock, fs, ds, sb;
        logic [7:0]  op;
        logic [3:0]  d, r0, r1, sbi;
        logic [15:0] alu, mem;
    } stim_t;

    typedef struct {
        logic        wbv;
        logic [3:0]  idx;
        logic [15:0] val;
        logic [15:0] busy;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [15:0] rf_m [16];
    bit          busy_m [16];
    int          cnt_m = 0;
    logic [3:0]  wbi_m = 4'h0;
    logic [15:0] wbval_m = 16'h0;
    bit          known = 1'b0;

    logic [7:0] writers [9] = '{ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, LDW, JSR, JSRR};
    logic [7:0] all_ops [18] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F,
                                 8'h20, 8'h21};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes_reg(input logic [7:0] o);
        foreach (writers[k]) if (writers[k] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] busy_vec();
        logic [15:0] v = 16'h0;
        for (int k = 0; k < 16; k++) v[k] = busy_m[k];
        return v;
    endfunction

    // One pipeline cycle: drive after the rising edge, check reads, predict.
    task automatic cyc(input stim_t s);
        bit          ret, com;
        logic [15:0] val, e0, e1;
        exp_t        e;
        @(posedge clk);
        rst = s.rst; lock = s.lock; fs = s.fs; ds = s.ds; op = s.op; dst = s.d;
        alu = s.alu; mem = s.mem; r0 = s.r0; r1 = s.r1; sb = s.sb; sbi = s.sbi;
        #1;
        ret = s.lock && !s.fs && !s.ds;
        com = ret && writes_reg(s.op);
        val = (s.op == LDW) ? s.mem : s.alu;
        e0 = rf_m[s.r0];
        e1 = rf_m[s.r1];
`ifdef WB_BYPASS_EN
        if (com && s.r0 == s.d) e0 = val;
        if (com && s.r1 == s.d) e1 = val;
`endif
        if (known) begin
            chk("rd0", {16'h0, rd0}, {16'h0, e0});
            chk("rd1", {16'h0, rd1}, {16'h0, e1});
        end
        if (s.rst) begin
            for (int k = 0; k < 16; k++) begin rf_m[k] = 16'h0; busy_m[k] = 1'b0; end
            cnt_m = 0; wbi_m = 4'h0; wbval_m = 16'h0; com = 1'b0;
            known = 1'b1;
        end else begin
            if (com) begin
                rf_m[s.d] = val; busy_m[s.d] = 1'b0; wbi_m = s.d; wbval_m = val;
            end
            if (s.sb) busy_m[s.sbi] = 1'b1;
            if (ret && cnt_m < (1 << CW) - 1) cnt_m++;
        end
        e.wbv = com; e.idx = wbi_m; e.val = wbval_m; e.busy = busy_vec(); e.cnt = cnt_m;
        exp_q.push_back(e);
    endtask

    // Monitor: after each falling edge has settled, compare registered outputs.
    always @(posedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_valid", {31'h0, wbv}, {31'h0, e.wbv});
            chk("wb_idx", {28'h0, wbi}, {28'h0, e.idx});
            chk("wb_value", {16'h0, wbval}, {16'h0, e.val});
            chk("busy_vec", {16'h0, busy}, {16'h0, e.busy});
            chk("retire_cnt", {24'h0, cnt}, e.cnt);
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.lock = 1'b0; s.fs = 1'b0; s.ds = 1'b0; s.sb = 1'b0;
        s.op = JMP; s.d = 4'h0; s.r0 = 4'h0; s.r1 = 4'h0; s.sbi = 4'h0;
        s.alu = 16'h0; s.mem = 16'h0;
        return s;
    endfunction

    function automatic stim_t instr(input logic [7:0] o, input logic [3:0] d,
                                    input logic [15:0] a, input logic [15:0] m);
        stim_t s = idle();
        s.lock = 1'b1; s.op = o; s.d = d; s.alu = a; s.mem = m;
        return s;
    endfunction

    initial begin
        stim_t s;
        for (int k = 0; k < 16; k++) begin rf_m[k] = 16'h0; busy_m[k] = 1'b0; end

        // Reset with a valid ADD_D present: reset must dominate.
        s = instr(ADD_D, 4'd3, 16'hBEEF, 16'h0); s.rst = 1'b1; s.sb = 1'b1; s.sbi = 4'd1;
        cyc(s);
        for (int k = 0; k < 16; k++) begin
            s = idle(); s.r0 = 4'(k); s.r1 = 4'(15 - k); cyc(s);
        end

        // ALU commit, then read back.
        cyc(instr(ADD_D, 4'd3, 16'h1234, 16'h0));
        s = idle(); s.r0 = 4'd3; cyc(s);
        // Load commit selects memory data.
        cyc(instr(LDW, 4'd5, 16'hAAAA, 16'h00BE));
        s = idle(); s.r0 = 4'd5; s.r1 = 4'd3; cyc(s);
        // Non-writers and a stalled writer.
        cyc(instr(STW, 4'd3, 16'h1111, 16'h2222));
        cyc(instr(BRZ, 4'd5, 16'h3333, 16'h4444));
        s = instr(ADD_D, 4'd3, 16'h5555, 16'h0); s.ds = 1'b1; cyc(s);
        s = instr(ADD_D, 4'd5, 16'h6666, 16'h0); s.fs = 1'b1; cyc(s);
        s = idle(); s.r0 = 4'd3; s.r1 = 4'd5; cyc(s);
        // Scoreboard collision on index 7, then a plain clear.
        s = idle(); s.sb = 1'b1; s.sbi = 4'd7; cyc(s);
        s = instr(MOV, 4'd7, 16'h0777, 16'h0); s.sb = 1'b1; s.sbi = 4'd7; cyc(s);
        cyc(instr(MOV, 4'd7, 16'h0778, 16'h0));
        // Set and clear on different indices in one cycle.
        s = instr(JSR, 4'd0, 16'h00A0, 16'h0); s.sb = 1'b1; s.sbi = 4'd9; cyc(s);
        // Same-cycle read of the committing register.
        s = instr(MOVI_D, 4'd2, 16'h0042, 16'h0); s.r0 = 4'd2; s.r1 = 4'd2; cyc(s);
        s = idle(); s.r0 = 4'd2; cyc(s);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 99) == 0);
            s.lock = ($urandom_range(0, 9) < 8);
            s.fs   = ($urandom_range(0, 9) == 0);
            s.ds   = ($urandom_range(0, 9) == 0);
            s.op   = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : all_ops[$urandom_range(0, 17)];
            s.d    = 4'($urandom());
            s.alu  = 16'($urandom());
            s.mem  = 16'($urandom());
            s.r0   = ($urandom_range(0, 3) == 0) ? s.d : 4'($urandom());
            s.r1   = 4'($urandom());
            s.sb   = ($urandom_range(0, 9) < 3);
            s.sbi  = ($urandom_range(0, 3) == 0) ? s.d : 4'($urandom());
            cyc(s);
        end

        // Drive the counter into saturation and beyond.
        for (int n = 0; n < 300; n++) cyc(instr(STW, 4'($urandom()), 16'h0, 16'h0));
        cyc(instr(ADDI_D, 4'd4, 16'h4444, 16'h0));
        cyc(idle());

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("count_saturated", {24'h0, cnt}, 32'd255);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage. Consumes the memory stage's registered outputs, selects the result (ALU result or load data), and commits it to the 16-entry architectural register file. Provides two read ports to decode, a per-register busy scoreboard (set by decode, cleared here on commit), and a retired-instruction counter.

Parameters:
NUM_REGS, 16, architectural register count; index width is 4.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
I_CLOCK  in  1  pipeline clock; all state updates on negedge, matching the other stages.
I_RESET  in  1  synchronous, active-high reset.
I_LOCK  in  1  pipeline-valid from the memory stage (its O_LOCK).
I_ALUOut  in  REG_WIDTH  ALU or link result from the memory stage.
I_MemOut  in  REG_WIDTH  load data from the memory stage.
I_Opcode  in  OPCODE_WIDTH  opcode of the instruction being retired.
I_DestRegIdx  in  4  destination register index.
I_FetchStall  in  1  bubble marker (fetch stall).
I_DepStall  in  1  bubble marker (dependency stall).
I_RdIdx0, I_RdIdx1  in  4 each  decode read addresses.
O_RdData0, O_RdData1  out  REG_WIDTH each  combinational read data.
I_SetBusy  in  1  decode issued a register-writing instruction.
I_SetBusyIdx  in  4  register to mark busy.
O_BusyVec  out  16  scoreboard; bit i set means register i has a pending write.
O_WBValid  out  1  registered: a commit occurred on the last edge.
O_WBIdx  out  4  registered index of the last commit.
O_WBValue  out  REG_WIDTH  registered value of the last commit.
O_RetireCount  out  CNT_WIDTH  count of retired non-bubble instructions.

Behaviour:
- Retire condition: retire = I_LOCK & ~I_FetchStall & ~I_DepStall.
- Commit condition: commit = retire & opcode in {ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, LDW, JSR, JSRR}.
- Commit value: I_MemOut for LDW; I_ALUOut for all other committing opcodes.
- Non-committing retirements (STW, BR*, JMP, unknown opcodes) write no register and do not touch the scoreboard.
- Reset (I_RESET=1 at a negedge) dominates all other inputs, including mid-operation. It clears:
  - all registers to 0;
  - O_BusyVec to 0;
  - O_RetireCount to 0;
  - O_WBValid, O_WBIdx and O_WBValue to 0.
- On commit, at the negedge:
  - RF[I_DestRegIdx] <= value;
  - busy bit cleared;
  - O_WBValid <= 1, O_WBIdx <= index, O_WBValue <= value.
- Otherwise: O_WBValid <= 0; O_WBIdx and O_WBValue hold.
- Scoreboard: I_SetBusy sets busy[I_SetBusyIdx] at the same negedge. If set and clear target the same index in one cycle, set wins (the newer producer is still outstanding). Set and clear on different indices both apply.
- Retire counter: increments by 1 on every retire, saturates at all-ones (no wrap).
- I_LOCK=0: no commit, no count, no scoreboard clear; I_SetBusy still honoured.
- Read ports:
  - Combinational from the register file; value written at edge N is visible after edge N.
  - No register is hardwired to zero; index 0 is an ordinary register.
- Latency: one negedge from a valid memory-stage output to the architectural update.

Optional Feature:
WB_BYPASS_EN.
- Defined: when commit is true in the current cycle and a read index equals I_DestRegIdx, that read port returns the commit value combinationally (same-cycle write-through).
- Undefined: read ports return stored register contents only; decode must wait one extra cycle via the scoreboard.

Test Plan:
- Reset: pulse I_RESET with I_LOCK=1 and a valid ADD_D present -> all registers read 0; O_BusyVec=0; O_RetireCount=0; O_WBValid=0 on the following cycle.
- ALU commit: ADD_D, idx=3, I_ALUOut=0x1234 -> O_WBValid=1, O_WBIdx=3, O_WBValue=0x1234; after the edge, reading index 3 returns 0x1234; O_RetireCount=1.
- Load commit: LDW, idx=5, I_ALUOut=0xAAAA, I_MemOut=0x00BE -> R5=0x00BE, not 0xAAAA.
- Bubbles and non-writers:
  - STW, then BRZ, then ADD_D with I_DepStall=1 -> no register change; O_WBValid=0 throughout.
  - Count goes up by 2 (STW, BRZ); the stalled ADD_D is not counted.
- Scoreboard collision: busy[7]=1 from an earlier issue; in one cycle commit idx 7 with I_SetBusy=1, I_SetBusyIdx=7 -> busy[7] stays 1.
  - Next cycle: commit idx 7 with no set -> busy[7]=0.
- Bypass and saturation:
  - With WB_BYPASS_EN: MOVI_D idx=2 value=0x0042 and I_RdIdx0=2 in the same cycle -> O_RdData0=0x0042 before the edge.
  - Without WB_BYPASS_EN: O_RdData0 shows the old value.
  - Preload the counter to all-ones, then retire -> counter stays all-ones.
